id_ex_stage: RTL and testbench

- Pipeline register between decode and execute in the RV32I core.
- Captures the decoded instruction fields and operands, and resolves EX/MEM and MEM/WB forwarding.
- Selects register or immediate for operand B and drives the ALU's funct7, funct3, A and B inputs directly.
- Also carries destination, PC and store data toward the EX/MEM register.

---
 rtl/core_pkg.sv | 20 ++
 rtl/fwd_mux.sv | 34 +++
 rtl/id_ex_stage.sv | 146 ++++++++++++++
 tb/tb_id_ex_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath widths and ALU funct encodings.
package core_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // funct3 encodings for the integer ALU operations
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 bit that selects SUB / SRA
    localparam int FUNCT7_ALT = 5;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding selector: picks the youngest in-flight producer of a
// source register, with EX/MEM taking priority over MEM/WB. x0 never forwards.
module fwd_mux #(
    parameter int DATA_W = core_pkg::XLEN,
    parameter int ADDR_W = core_pkg::REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic              mem_reg_write,
    input  logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_rd_addr,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] fwd_data
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs_addr);
    assign wb_hit  = wb_reg_write  && (wb_rd_addr  != '0) && (wb_rd_addr  == rs_addr);

    // Priority select: newer EX/MEM result beats older MEM/WB result
    always_comb begin
        fwd_data = rs_data;
        if (mem_hit) begin
            fwd_data = mem_result;
        end else if (wb_hit) begin
            fwd_data = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32I core. Holds the decoded instruction,
// resolves forwarding for both source operands and drives the ALU inputs.
module id_ex_stage #(
    parameter int         XLEN       = core_pkg::XLEN,
    parameter int         REG_ADDR_W = core_pkg::REG_ADDR_W,
    parameter logic [2:0] NOP_FUNCT3 = core_pkg::F3_ADD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic [6:0]            id_funct7,
    input  logic [2:0]            id_funct3,
    input  logic                  id_use_imm,
    input  logic                  id_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic                  mem_reg_write,
    input  logic [XLEN-1:0]       mem_result,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic                  wb_reg_write,
    input  logic [XLEN-1:0]       wb_result,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [6:0]            ex_funct7,
    output logic [2:0]            ex_funct3,
    output logic [XLEN-1:0]       ex_a,
    output logic [XLEN-1:0]       ex_b,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_reg_write
);

    logic                  valid_q;
    logic [XLEN-1:0]       pc_q;
    logic [XLEN-1:0]       rs1_data_q;
    logic [XLEN-1:0]       rs2_data_q;
    logic [XLEN-1:0]       imm_q;
    logic [REG_ADDR_W-1:0] rs1_addr_q;
    logic [REG_ADDR_W-1:0] rs2_addr_q;
    logic [REG_ADDR_W-1:0] rd_addr_q;
    logic [6:0]            funct7_q;
    logic [2:0]            funct3_q;
    logic                  use_imm_q;
    logic                  reg_write_q;

    logic [XLEN-1:0]       fwd_rs1;
    logic [XLEN-1:0]       fwd_rs2;

    fwd_mux #(
        .DATA_W (XLEN),
        .ADDR_W (REG_ADDR_W)
    ) u_fwd_rs1 (
        .rs_addr       (rs1_addr_q),
        .rs_data       (rs1_data_q),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_result     (wb_result),
        .fwd_data      (fwd_rs1)
    );

    fwd_mux #(
        .DATA_W (XLEN),
        .ADDR_W (REG_ADDR_W)
    ) u_fwd_rs2 (
        .rs_addr       (rs2_addr_q),
        .rs_data       (rs2_data_q),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_result     (wb_result),
        .fwd_data      (fwd_rs2)
    );

    // Pipeline register: reset > flush > stall > load. While stalled the
    // operand registers re-latch their forwarded value so a producer that
    // retires out of MEM/WB during the stall is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            funct7_q    <= '0;
            funct3_q    <= NOP_FUNCT3;
            use_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            funct7_q    <= '0;
            funct3_q    <= NOP_FUNCT3;
        end else if (stall) begin
            rs1_data_q  <= fwd_rs1;
            rs2_data_q  <= fwd_rs2;
        end else begin
            valid_q     <= id_valid;
            pc_q        <= id_pc;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            rs1_addr_q  <= id_rs1_addr;
            rs2_addr_q  <= id_rs2_addr;
            rd_addr_q   <= id_rd_addr;
            funct7_q    <= id_funct7;
            funct3_q    <= id_funct3;
            use_imm_q   <= id_use_imm;
            reg_write_q <= id_reg_write & id_valid;
        end
    end

    // ALU drive: immediate forms only honour funct7 for shifts-right, since
    // for ADDI/SLTI etc. those bits are immediate and must not select SUB.
    always_comb begin
        ex_funct7 = funct7_q;
        if (use_imm_q && (funct3_q != core_pkg::F3_SR)) begin
            ex_funct7 = '0;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_funct3     = funct3_q;
    assign ex_a          = fwd_rs1;
    assign ex_b          = use_imm_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_reg_write  = reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for the ID/EX pipeline register.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [4:0]  id_rd_addr;
    logic [6:0]  id_funct7;
    logic [2:0]  id_funct3;
    logic        id_use_imm;
    logic        id_reg_write;
    logic [4:0]  mem_rd_addr;
    logic        mem_reg_write;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_write;
    logic [31:0] wb_result;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [6:0]  ex_funct7;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;

    int checks;
    int fails;

    id_ex_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_rd_addr    (id_rd_addr),
        .id_funct7     (id_funct7),
        .id_funct3     (id_funct3),
        .id_use_imm    (id_use_imm),
        .id_reg_write  (id_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd_addr    (wb_rd_addr),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_funct7     (ex_funct7),
        .ex_funct3     (ex_funct3),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_store_data (ex_store_data),
        .ex_rd_addr    (ex_rd_addr),
        .ex_reg_write  (ex_reg_write)
    );

    // 10-time-unit core clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                             input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                             input logic [31:0] imm, input logic [6:0] f7, input logic [2:0] f3,
                             input logic use_imm, input logic reg_write);
        id_valid     = 1'b1;
        id_pc        = pc;
        id_rs1_addr  = rs1;
        id_rs1_data  = d1;
        id_rs2_addr  = rs2;
        id_rs2_data  = d2;
        id_rd_addr   = rd;
        id_imm       = imm;
        id_funct7    = f7;
        id_funct3    = f3;
        id_use_imm   = use_imm;
        id_reg_write = reg_write;
    endtask

    task automatic no_forward();
        mem_reg_write = 1'b0;
        mem_rd_addr   = 5'd0;
        mem_result    = 32'h0;
        wb_reg_write  = 1'b0;
        wb_rd_addr    = 5'd0;
        wb_result     = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++; if (ex_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %0b expected 0", ex_valid); end
        checks++; if (ex_funct3 !== 3'b000) begin fails++; $display("[TB] FAIL reset_funct3: got %0h expected 0", ex_funct3); end
        checks++; if (ex_b !== 32'h0) begin fails++; $display("[TB] FAIL reset_b: got %h expected 0", ex_b); end
        @(negedge clk);
        rst = 1'b0;
        // ADD x3,x1,x2 then asynchronous reset mid-cycle
        set_instr(32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'h0, 7'h00, 3'b000, 1'b0, 1'b1);
        step();
        checks++; if (ex_a !== 32'd5 || ex_b !== 32'd7) begin fails++; $display("[TB] FAIL add_load: got a=%h b=%h expected a=5 b=7", ex_a, ex_b); end
        checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin fails++; $display("[TB] FAIL add_valid: got v=%0b rw=%0b expected 1 1", ex_valid, ex_reg_write); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_a !== 32'h0) begin fails++; $display("[TB] FAIL async_reset: got v=%0b rw=%0b a=%h expected 0 0 0", ex_valid, ex_reg_write, ex_a); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_addi();
        // ADDI x5,x0,-1 with funct7 bits all set by the immediate
        set_instr(32'h104, 5'd0, 32'h0, 5'd31, 32'h1234, 5'd5, 32'hFFFF_FFFF, 7'h7F, 3'b000, 1'b1, 1'b1);
        step();
        checks++; if (ex_funct7 !== 7'h00) begin fails++; $display("[TB] FAIL addi_funct7: got %h expected 00", ex_funct7); end
        checks++; if (ex_b !== 32'hFFFF_FFFF || ex_a !== 32'h0) begin fails++; $display("[TB] FAIL addi_ops: got a=%h b=%h expected a=0 b=ffffffff", ex_a, ex_b); end
        checks++; if (ex_store_data !== 32'h1234) begin fails++; $display("[TB] FAIL addi_store: got %h expected 00001234", ex_store_data); end
    endtask

    task automatic test_srai();
        set_instr(32'h108, 5'd4, 32'h9, 5'd3, 32'h0, 5'd4, 32'h403, 7'h20, 3'b101, 1'b1, 1'b1);
        step();
        checks++; if (ex_funct7 !== 7'h20 || ex_funct3 !== 3'b101) begin fails++; $display("[TB] FAIL srai_funct: got f7=%h f3=%h expected 20 5", ex_funct7, ex_funct3); end
        checks++; if (ex_b !== 32'h403 || ex_a !== 32'h9) begin fails++; $display("[TB] FAIL srai_ops: got a=%h b=%h expected a=9 b=403", ex_a, ex_b); end
    endtask

    task automatic test_forwarding();
        set_instr(32'h10C, 5'd6, 32'h99, 5'd7, 32'h1, 5'd8, 32'h0, 7'h00, 3'b000, 1'b0, 1'b1);
        mem_reg_write = 1'b1; mem_rd_addr = 5'd6; mem_result = 32'h11;
        wb_reg_write  = 1'b1; wb_rd_addr  = 5'd6; wb_result  = 32'h22;
        step();
        checks++; if (ex_a !== 32'h11) begin fails++; $display("[TB] FAIL fwd_mem_prio: got %h expected 11", ex_a); end
        checks++; if (ex_store_data !== 32'h1) begin fails++; $display("[TB] FAIL fwd_rs2_none: got %h expected 1", ex_store_data); end
        mem_reg_write = 1'b0;
        #1;
        checks++; if (ex_a !== 32'h22) begin fails++; $display("[TB] FAIL fwd_wb: got %h expected 22", ex_a); end
        wb_reg_write = 1'b0;
        #1;
        checks++; if (ex_a !== 32'h99) begin fails++; $display("[TB] FAIL fwd_none: got %h expected 99", ex_a); end
        // x0 as source and as producer destination must never forward
        set_instr(32'h110, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 32'h0, 7'h00, 3'b000, 1'b0, 1'b1);
        mem_reg_write = 1'b1; mem_rd_addr = 5'd0; mem_result = 32'hDEAD;
        wb_reg_write  = 1'b1; wb_rd_addr  = 5'd0; wb_result  = 32'hBEEF;
        step();
        checks++; if (ex_a !== 32'h0 || ex_b !== 32'h0) begin fails++; $display("[TB] FAIL fwd_x0: got a=%h b=%h expected 0 0", ex_a, ex_b); end
        no_forward();
    endtask

    task automatic test_stall_capture();
        set_instr(32'h200, 5'd1, 32'h10, 5'd2, 32'hAA, 5'd8, 32'h0, 7'h00, 3'b000, 1'b0, 1'b1);
        step();
        // junk on the decode side must not be captured during the stall
        set_instr(32'h300, 5'd11, 32'h77, 5'd12, 32'h66, 5'd13, 32'h5, 7'h20, 3'b111, 1'b1, 1'b1);
        stall = 1'b1;
        wb_reg_write = 1'b1; wb_rd_addr = 5'd2; wb_result = 32'h55;
        step();
        no_forward();
        step();
        stall = 1'b0;
        #1;
        checks++; if (ex_b !== 32'h55) begin fails++; $display("[TB] FAIL stall_capture: got %h expected 55", ex_b); end
        checks++; if (ex_pc !== 32'h200 || ex_rd_addr !== 5'd8 || ex_a !== 32'h10) begin fails++; $display("[TB] FAIL stall_hold: got pc=%h rd=%0d a=%h expected 200 8 10", ex_pc, ex_rd_addr, ex_a); end
        checks++; if (ex_valid !== 1'b1 || ex_funct3 !== 3'b000) begin fails++; $display("[TB] FAIL stall_ctrl: got v=%0b f3=%h expected 1 0", ex_valid, ex_funct3); end
    endtask

    task automatic test_flush_stall();
        set_instr(32'h380, 5'd1, 32'h1, 5'd2, 32'h2, 5'd10, 32'h0, 7'h20, 3'b111, 1'b0, 1'b1);
        step();
        flush = 1'b1;
        stall = 1'b1;
        step();
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin fails++; $display("[TB] FAIL flush_stall: got v=%0b rw=%0b expected 0 0", ex_valid, ex_reg_write); end
        checks++; if (ex_funct3 !== 3'b000 || ex_funct7 !== 7'h00) begin fails++; $display("[TB] FAIL flush_funct: got f3=%h f7=%h expected 0 0", ex_funct3, ex_funct7); end
        flush = 1'b0;
        stall = 1'b0;
        set_instr(32'h400, 5'd3, 32'h33, 5'd4, 32'h44, 5'd9, 32'h0, 7'h00, 3'b110, 1'b0, 1'b1);
        step();
        checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_pc !== 32'h400) begin fails++; $display("[TB] FAIL after_flush: got v=%0b rw=%0b pc=%h expected 1 1 400", ex_valid, ex_reg_write, ex_pc); end
        // write enable must be gated by an invalid decode slot
        id_valid = 1'b0;
        step();
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin fails++; $display("[TB] FAIL rw_gate: got v=%0b rw=%0b expected 0 0", ex_valid, ex_reg_write); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        stall  = 1'b0;
        flush  = 1'b0;
        set_instr(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 7'h00, 3'b000, 1'b0, 1'b0);
        id_valid = 1'b0;
        no_forward();
        test_reset();
        test_addi();
        test_srai();
        test_forwarding();
        test_stall_capture();
        test_flush_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
